// File: rtl/crt_recombine_if.sv
// CRT recombination request/response bundle: operands in, recombined plaintext out.
// Latency: none (wiring only).
// Backpressure: none; the requester pulses start and waits for done, while busy marks the stage as occupied.
// Ports: start/mp/mq/p/q/qinv carry the request (N bits each); result (2N bits), done and busy carry the response.
interface crt_recombine_if #(
  parameter int N = 512
);
  logic           start;
  logic [N-1:0]   mp;
  logic [N-1:0]   mq;
  logic [N-1:0]   p;
  logic [N-1:0]   q;
  logic [N-1:0]   qinv;
  logic [2*N-1:0] result;
  logic           done;
  logic           busy;

  modport master (
    output start, mp, mq, p, q, qinv,
    input  result, done, busy
  );

  modport slave (
    input  start, mp, mq, p, q, qinv,
    output result, done, busy
  );
endinterface

// File: rtl/crt_recombine.sv
// Garner CRT recombination m = mq + q*(((mp - mq) mod p) * qinv mod p), bit-serial.
// Latency: done pulses 2N+4 cycles after the edge that accepts start (RED, SUB, N MODMUL, N MUL, ADD, DONE).
// Backpressure: none; start is honoured only in IDLE and is ignored while busy or in the DONE cycle.
// Ports: clk, resetn (asynchronous, active-high despite its name), bus (slave side of crt_recombine_if):
//   start/mp/mq/p/q/qinv in; result (held from done until the next accepted start), done, busy out.
module crt_recombine #(
  parameter int N = 512
) (
  input  logic        clk,
  input  logic        resetn,
  crt_recombine_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE, RED, SUB, MODMUL, MUL, ADD, DONE
  } state_t;

  state_t state, state_nxt;

  // Operands latched on the accepting edge so the requester may change its inputs freely afterwards.
  logic [N-1:0]   mp_r, mq_r, p_r, q_r;
  // Multiplier shift register: holds qinv during MODMUL, then is reloaded with h for MUL.
  logic [N-1:0]   mult_sr;
  logic [N-1:0]   t_r;
  logic [N:0]     d_r;
  logic [N+1:0]   acc;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] result_r;
  logic [CW-1:0]  cnt;
  logic           busy, done;

  logic           last;
  logic [N+1:0]   p_ext;
  logic [N+1:0]   dbl, dbl_red, acc_add, acc_step;
  logic [N:0]     d_nxt;
  logic [N-1:0]   t_nxt;
  logic [2*N-1:0] prod_step;

  assign bus.result = result_r;
  assign bus.busy   = busy;
  assign bus.done   = done;

  assign last  = (cnt == CW'(N - 1));
  assign p_ext = {2'b00, p_r};

  // Since q < 2p, one conditional subtraction brings mq below p.
  assign t_nxt = (mq_r >= p_r) ? (mq_r - p_r) : mq_r;

  // (mp - t) mod p at N+1 bits; the +p branch cannot overflow N+1 bits.
  assign d_nxt = (mp_r >= t_r) ? ({1'b0, mp_r} - {1'b0, t_r})
                               : ({1'b0, mp_r} + {1'b0, p_r} - {1'b0, t_r});

  // One interleaved modular-multiply step: double, reduce, conditionally add d, reduce.
  always_comb begin
    dbl      = acc << 1;
    dbl_red  = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
    acc_add  = dbl_red + (mult_sr[N-1] ? {1'b0, d_r} : '0);
    acc_step = (acc_add >= p_ext) ? (acc_add - p_ext) : acc_add;
  end

  // One shift-add step of h*q, MSB of h first.
  assign prod_step = (prod << 1) + (mult_sr[N-1] ? {{N{1'b0}}, q_r} : '0);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_nxt = RED;
      RED:    begin busy = 1'b1; state_nxt = SUB; end
      SUB:    begin busy = 1'b1; state_nxt = MODMUL; end
      MODMUL: begin busy = 1'b1; if (last) state_nxt = MUL; end
      MUL:    begin busy = 1'b1; if (last) state_nxt = ADD; end
      ADD:    begin busy = 1'b1; state_nxt = DONE; end
      DONE:   begin done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      mp_r     <= '0;
      mq_r     <= '0;
      p_r      <= '0;
      q_r      <= '0;
      mult_sr  <= '0;
      t_r      <= '0;
      d_r      <= '0;
      acc      <= '0;
      prod     <= '0;
      result_r <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mp_r    <= bus.mp;
            mq_r    <= bus.mq;
            p_r     <= bus.p;
            q_r     <= bus.q;
            mult_sr <= bus.qinv;
          end
        end
        RED: begin
          t_r <= t_nxt;
        end
        SUB: begin
          d_r  <= d_nxt;
          acc  <= '0;
          prod <= '0;
          cnt  <= '0;
        end
        MODMUL: begin
          acc <= acc_step;
          // On the final bit the reduced accumulator is h; load it as the next multiplier.
          mult_sr <= last ? acc_step[N-1:0] : (mult_sr << 1);
          cnt     <= last ? '0 : cnt + CW'(1);
        end
        MUL: begin
          prod    <= prod_step;
          mult_sr <= mult_sr << 1;
          cnt     <= last ? '0 : cnt + CW'(1);
        end
        ADD: begin
          result_r <= prod + {{N{1'b0}}, mq_r};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crt_recombine.sv
module tb_crt_recombine;

  localparam int N   = 8;
  localparam int LAT = 2 * N + 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  crt_recombine_if #(.N(N)) bus ();

  crt_recombine #(.N(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int primes[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.mp   = N'($urandom);
    bus.mq   = N'($urandom);
    bus.p    = N'($urandom);
    bus.q    = N'($urandom);
    bus.qinv = N'($urandom);
  endtask

  // Issues one request (clock low on entry) and follows it to the idle cycle after done.
  // rp1/rp2 name cycles (1 = first busy cycle) in which start is raised again with junk operands.
  task automatic run_op(input string tag,
                        input logic [N-1:0] a_mp, input logic [N-1:0] a_mq,
                        input logic [N-1:0] a_p, input logic [N-1:0] a_q,
                        input logic [N-1:0] a_qinv,
                        input logic [2*N-1:0] exp_res, input bit chk_res,
                        input int rp1, input int rp2);
    int n, done_at, busy_cnt;
    logic [2*N-1:0] res_at_done;
    bus.mp    = a_mp;
    bus.mq    = a_mq;
    bus.p     = a_p;
    bus.q     = a_q;
    bus.qinv  = a_qinv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    n        = 1;
    done_at  = 0;
    busy_cnt = 0;
    while (done_at == 0 && n <= 3 * LAT) begin
      @(negedge clk);
      if (bus.done) done_at = n;
      else if (bus.busy) busy_cnt++;
      bus.start = (n == rp1 || n == rp2);
      if (bus.start) scramble_inputs();
      if (done_at == 0) begin
        @(posedge clk);
        n++;
      end
    end
    check({tag, ".latency"}, done_at, LAT);
    check({tag, ".busy_cycles"}, busy_cnt, LAT - 1);
    if (chk_res) check({tag, ".result"}, bus.result, exp_res);
    res_at_done = bus.result;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".done_after"}, bus.done, 1'b0);
    check({tag, ".busy_after"}, bus.busy, 1'b0);
    check({tag, ".result_held"}, bus.result, res_at_done);
  endtask

  initial begin
    int p, q, qinv, c, gap, ndone, nbusy;
    bus.start = 1'b0;
    bus.mp = '0; bus.mq = '0; bus.p = '0; bus.q = '0; bus.qinv = '0;

    for (int k = 2; k < (1 << N); k++) begin
      bit is_p;
      is_p = 1'b1;
      for (int j = 2; j * j <= k; j++) if (k % j == 0) is_p = 1'b0;
      if (is_p) primes.push_back(k);
    end

    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.result", bus.result, 0);
    check("reset.done", bus.done, 0);
    check("reset.busy", bus.busy, 0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);

    run_op("basic",   1,  9, 11, 13, 6, 100, 1'b1, -1, -1);
    run_op("mq_ge_p", 6, 11, 11, 13, 6,  50, 1'b1, -1, -1);
    run_op("max",    10, 12, 11, 13, 6, 142, 1'b1, -1, -1);
    run_op("eq",      5,  5, 11, 13, 6,   5, 1'b1, -1, -1);
    run_op("qinv0",   3,  7, 11, 13, 0,   7, 1'b1, -1, -1);
    run_op("repulse", 1,  9, 11, 13, 6, 100, 1'b1,  5, 19);
    run_op("in_done", 6, 11, 11, 13, 6,  50, 1'b1, LAT, -1);
    run_op("b2b",    10, 12, 11, 13, 6, 142, 1'b1, -1, -1);

    // Abort mid-operation: outputs clear asynchronously and no done follows.
    bus.mp = 1; bus.mq = 9; bus.p = 11; bus.q = 13; bus.qinv = 6;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    check("abort.result", bus.result, 0);
    check("abort.done", bus.done, 0);
    check("abort.busy", bus.busy, 0);
    @(negedge clk);
    resetn = 1'b0;
    ndone = 0;
    nbusy = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) nbusy++;
    end
    check("abort.no_done", ndone, 0);
    check("abort.no_busy", nbusy, 0);
    run_op("after_abort", 1, 9, 11, 13, 6, 100, 1'b1, -1, -1);

    // Random keys: pick C < pq, split into residues, expect C back.
    for (int it = 0; it < 150; it++) begin
      do begin
        p = primes[$urandom_range(0, primes.size() - 1)];
        q = primes[$urandom_range(0, primes.size() - 1)];
      end while (p == q || q >= 2 * p);
      qinv = 0;
      for (int k = 1; k < p; k++) if ((q * k) % p == 1) qinv = k;
      c   = int'($urandom_range(0, p * q - 1));
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      run_op("rand", N'(c % p), N'(c % q), N'(p), N'(q), N'(qinv), (2*N)'(c), 1'b1,
             (it % 3 == 0) ? int'($urandom_range(1, LAT)) : -1, -1);
    end

    // Operands outside the preconditions: result is don't-care, timing is not.
    for (int it = 0; it < 15; it++) begin
      run_op("junk", N'($urandom), N'($urandom), N'($urandom), N'($urandom), N'($urandom),
             '0, 1'b0, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
